hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/mips_pkg.sv | 7 +
 rtl/hazard_match.sv | 12 +
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared hazard-control types and constants
// Exports: state_t (RUN, MEM_WAIT), REG_ZERO (hard-wired zero register), CNT_W (perf counter width)
package mips_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int CNT_W = 32;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: flags an ID-stage source that reads a producer's destination register
// Ports: rd (producer destination), rs/rt (consumer sources), hit (nonzero rd equals rs or rt)
module hazard_match
  import mips_pkg::*;
(
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hit
);
  assign hit = (rd != REG_ZERO) && (rd == rs || rd == rt);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, branch-load and cache-miss hazards
// Inputs: clk, rst_n (async active-low), EX/MEM producer info, ID consumer/branch info, cache stalls
// Outputs: StallF..StallW hold PC and pipeline registers; FlushD/FlushE bubble IF/ID and ID/EX
// Option: define HAZARD_PERF_EN to add saturating lu_stall_cnt and mem_stall_cnt outputs
module hazard_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RegWrite_IE,
  input  logic       MemtoReg_IE,
  input  logic       MemtoReg_EM,
  input  logic [4:0] RegisterRd_IE,
  input  logic [4:0] RegisterRd_EM,
  input  logic [4:0] RegisterRs_FD,
  input  logic [4:0] RegisterRt_FD,
  input  logic       Branch_FD,
  input  logic       BranchTaken_FD,
  input  logic       ICacheStall,
  input  logic       DCacheStall,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
`endif
);
  state_t state, state_d;
  logic pend_flush, pend_d;
  logic hit_ie, hit_em, memstall, lu, lu_act;

  hazard_match u_match_ie (.rd(RegisterRd_IE), .rs(RegisterRs_FD), .rt(RegisterRt_FD), .hit(hit_ie));
  hazard_match u_match_em (.rd(RegisterRd_EM), .rs(RegisterRs_FD), .rt(RegisterRt_FD), .hit(hit_em));

  assign memstall = ICacheStall | DCacheStall;
  assign lu = (MemtoReg_IE & RegWrite_IE & hit_ie) | (Branch_FD & MemtoReg_EM & hit_em);
  assign lu_act = rst_n & ~memstall & lu;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      pend_flush <= 1'b0;
    end else begin
      state <= state_d;
      pend_flush <= pend_d;
    end

  // Outputs are forced low during reset even though inputs may still be active.
  // A taken branch seen when a miss begins is remembered so its wrong-path fetch is flushed on exit.
  always_comb begin
    state_d = state;
    pend_d = pend_flush;
    {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE} = '0;
    if (!rst_n) begin
      state_d = RUN;
      pend_d = 1'b0;
    end else if (memstall) begin
      {StallF, StallD, StallE, StallM, StallW} = '1;
      state_d = MEM_WAIT;
      pend_d = (state == RUN) ? BranchTaken_FD : pend_flush;
    end else begin
      StallF = lu;
      StallD = lu;
      FlushE = lu;
      FlushD = (state == MEM_WAIT && pend_flush) || (!lu && BranchTaken_FD);
      state_d = RUN;
      pend_d = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lu_stall_cnt <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (lu_act && !(&lu_stall_cnt)) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      if (memstall && !(&mem_stall_cnt)) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
    end
`else
  logic unused;
  assign unused = lu_act;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks of hazard_ctrl stall/flush behaviour
module tb_hazard_ctrl;
  logic clk = 0, rst_n = 0;
  logic rw_ie, m2r_ie, m2r_em, br, bt, ic, dc;
  logic [4:0] rd_ie, rd_em, rs, rt;
  logic sf, sd, se, sm, sw, fd, fe;
  int checks = 0, errors = 0;
`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt, mem_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_IE(rw_ie), .MemtoReg_IE(m2r_ie), .MemtoReg_EM(m2r_em),
    .RegisterRd_IE(rd_ie), .RegisterRd_EM(rd_em),
    .RegisterRs_FD(rs), .RegisterRt_FD(rt),
    .Branch_FD(br), .BranchTaken_FD(bt),
    .ICacheStall(ic), .DCacheStall(dc),
    .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm), .StallW(sw),
    .FlushD(fd), .FlushE(fe)
`ifdef HAZARD_PERF_EN
    , .lu_stall_cnt(lu_cnt), .mem_stall_cnt(mem_cnt)
`endif
  );

  typedef struct {
    logic rw_ie, m2r_ie, m2r_em;
    logic [4:0] rd_ie, rd_em, rs, rt;
    logic br, bt, ic, dc;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(logic a, logic b, logic c, logic [4:0] d, logic [4:0] e,
                              logic [4:0] f, logic [4:0] g, logic h, logic i, logic j,
                              logic k, logic [6:0] x);
    vec_t v;
    v.rw_ie = a; v.m2r_ie = b; v.m2r_em = c; v.rd_ie = d; v.rd_em = e;
    v.rs = f; v.rt = g; v.br = h; v.bt = i; v.ic = j; v.dc = k; v.exp = x;
    return v;
  endfunction

  task automatic drive(vec_t v);
    rw_ie = v.rw_ie; m2r_ie = v.m2r_ie; m2r_em = v.m2r_em; rd_ie = v.rd_ie; rd_em = v.rd_em;
    rs = v.rs; rt = v.rt; br = v.br; bt = v.bt; ic = v.ic; dc = v.dc;
  endtask

  // Checks outputs at the negedge, then advances to just after the next posedge.
  task automatic check(string name, logic [6:0] exp);
    logic [6:0] got;
    @(negedge clk);
    got = {sf, sd, se, sm, sw, fd, fe};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (StallF,D,E,M,W,FlushD,FlushE)", name, got, exp);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] Z = 7'b0000000, LU = 7'b1100001, MS = 7'b1111100, FDO = 7'b0000010;
  vec_t tbl[16];
  vec_t clr, lu_v;

  initial begin
    clr  = mk(0,0,0, 0,0,0,0, 0,0,0,0, Z);
    lu_v = mk(1,1,0, 8,0,0,8, 0,0,0,0, LU);
    tbl[0]  = clr;
    tbl[1]  = lu_v;
    tbl[2]  = clr;
    tbl[3]  = mk(1,1,0, 0,0,0,0, 0,0,0,0, Z);
    tbl[4]  = mk(1,1,0, 12,0,12,3, 1,1,0,0, LU);
    tbl[5]  = mk(1,0,0, 8,0,0,8, 0,0,0,0, Z);
    tbl[6]  = mk(0,0,1, 0,9,9,0, 1,1,0,0, LU);
    tbl[7]  = mk(0,0,1, 0,9,9,0, 0,0,0,0, Z);
    tbl[8]  = mk(0,0,0, 0,0,0,0, 0,1,0,0, FDO);
    tbl[9]  = mk(0,1,0, 8,0,0,8, 0,0,0,0, Z);
    tbl[10] = mk(0,0,0, 0,0,0,0, 0,1,1,0, MS);
    tbl[11] = mk(0,0,0, 0,0,0,0, 0,0,0,0, FDO);
    tbl[12] = clr;
    tbl[13] = mk(1,1,0, 8,0,0,8, 0,0,0,1, MS);
    tbl[14] = lu_v;
    tbl[15] = clr;

    drive(lu_v);
    ic = 1;
    #2;
    check("reset_outputs", Z);
    rst_n = 1;
    drive(clr);

    drive(lu_v);
    check("load_use", LU);
    drive(clr);
    check("load_use_next", Z);

    dc = 1; bt = 1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("miss_c%0d", i + 1), MS);
      bt = 0;
    end
    dc = 0;
    check("miss_exit_flushd", FDO);
    check("miss_after", Z);
`ifdef HAZARD_PERF_EN
    checks++;
    if (lu_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_stall_cnt: got %0d expected 1", lu_cnt);
    end
    checks++;
    if (mem_cnt !== 32'd5) begin
      errors++;
      $display("FAIL mem_stall_cnt: got %0d expected 5", mem_cnt);
    end
`endif

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    drive(clr);
    ic = 1; bt = 1;
    check("rmiss_c1", MS);
    bt = 0;
    check("rmiss_c2", MS);
    rst_n = 0;
    check("rmiss_in_reset", Z);
    rst_n = 1;
    ic = 0;
    for (int i = 0; i < 3; i++) check($sformatf("rmiss_post%0d", i), Z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
